// File: rtl/riscv_pkg.sv
// Shared RISC-V control constants: FSM state codes, opcodes, ALU op classes
// and the control-word bundle produced by the control unit.
package riscv_pkg;

    localparam logic [3:0] EST_BUSCA       = 4'b0000;
    localparam logic [3:0] EST_DECODIFICA  = 4'b0001;
    localparam logic [3:0] EST_EXEC_R      = 4'b0010;
    localparam logic [3:0] EST_EXEC_I      = 4'b0011;
    localparam logic [3:0] EST_CALC_END    = 4'b0100;
    localparam logic [3:0] EST_LE_MEM      = 4'b0101;
    localparam logic [3:0] EST_ESCREVE_MEM = 4'b0110;
    localparam logic [3:0] EST_ESCREVE_REG = 4'b0111;
    localparam logic [3:0] EST_DESVIO      = 4'b1000;
    localparam logic [3:0] EST_PARADO      = 4'b1111;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic fim_de_programa(input logic [31:0] pc, input logic [31:0] limite);
        return pc >= limite;
    endfunction

endpackage

// File: rtl/unidadecontrole_if.sv
// Control-unit <-> datapath bundle: instruction/flag in, state, PC and control strobes out.
interface unidadecontrole_if;
    logic [31:0] instrucao;
    logic        zero;
    logic [3:0]  estado;
    logic [31:0] PC;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        erro;
    logic [15:0] n_exec;

    modport master (
        input  instrucao, zero,
        output estado, PC, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src, alu_op, erro, n_exec
    );

    modport slave (
        output instrucao, zero,
        input  estado, PC, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src, alu_op, erro, n_exec
    );
endinterface

// File: rtl/unidadecontrole_gerador_imediato.sv
// Immediate generator: extracts and sign-extends the B-type immediate
// (13 bits, byte offset, bit 0 always zero) from an instruction word.
module gerador_imediato (
    input  logic [31:0] instrucao,
    output logic [31:0] imm_b
);
    logic unused_campos;

    assign imm_b = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                    instrucao[30:25], instrucao[11:8], 1'b0};

    assign unused_campos = ^{instrucao[24:12], instrucao[6:0]};
endmodule

// File: rtl/unidadecontrole.sv
// Multicycle RISC-V control unit: owns PC and the fetch-stage state bus and
// sequences fetch, decode, execute, memory and write-back.
module unidadecontrole
    import riscv_pkg::*;
#(
    parameter int N_INSTR = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    unidadecontrole_if.master bus
);
    localparam logic [31:0] PC_LIMITE = 32'(N_INSTR);

    logic [3:0]  estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_atual_q, pc_atual_d;
    logic [6:0]  opcode_r_q, opcode_r_d;
    logic        erro_q, erro_d;
    logic [15:0] n_exec_q, n_exec_d;
    logic [31:0] imm_b;
    logic [31:0] alvo_desvio;
    ctrl_t       ctrl;

    gerador_imediato u_gerador_imediato (
        .instrucao (bus.instrucao),
        .imm_b     (imm_b)
    );

    // Branch offset is in bytes; PC counts words, so shift arithmetically.
    assign alvo_desvio = pc_atual_q + $unsigned($signed(imm_b) >>> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= EST_BUSCA;
            pc_q       <= '0;
            pc_atual_q <= '0;
            opcode_r_q <= '0;
            erro_q     <= 1'b0;
            n_exec_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            pc_atual_q <= pc_atual_d;
            opcode_r_q <= opcode_r_d;
            erro_q     <= erro_d;
            n_exec_q   <= n_exec_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        pc_atual_d = pc_atual_q;
        opcode_r_d = opcode_r_q;
        erro_d     = erro_q;
        n_exec_d   = n_exec_q;
        case (estado_q)
            EST_BUSCA: begin
                estado_d   = EST_DECODIFICA;
                pc_atual_d = pc_q;
                pc_d       = pc_q + 32'd1;
            end
            EST_DECODIFICA: begin
                opcode_r_d = bus.instrucao[6:0];
                case (bus.instrucao[6:0])
                    OP_R:         estado_d = EST_EXEC_R;
                    OP_I:         estado_d = EST_EXEC_I;
                    OP_LW, OP_SW: estado_d = EST_CALC_END;
                    OP_BEQ:       estado_d = EST_DESVIO;
                    default: begin
                        estado_d = EST_PARADO;
                        erro_d   = 1'b1;
                    end
                endcase
            end
            EST_EXEC_R, EST_EXEC_I: estado_d = EST_ESCREVE_REG;
            EST_CALC_END: estado_d = (opcode_r_q == OP_LW) ? EST_LE_MEM : EST_ESCREVE_MEM;
            EST_LE_MEM:   estado_d = EST_ESCREVE_REG;
            EST_ESCREVE_REG, EST_ESCREVE_MEM, EST_DESVIO: begin
                if (estado_q == EST_DESVIO && bus.zero)
                    pc_d = alvo_desvio;
                n_exec_d = n_exec_q + 16'd1;
                // A wrapped negative target is a huge unsigned PC and halts too.
                estado_d = fim_de_programa(pc_d, PC_LIMITE) ? EST_PARADO : EST_BUSCA;
            end
            EST_PARADO: estado_d = EST_PARADO;
            default:    estado_d = EST_BUSCA;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (estado_q)
            EST_EXEC_R: ctrl.alu_op = ALU_FUNCT;
            EST_EXEC_I: begin
                ctrl.alu_op  = ALU_FUNCT;
                ctrl.alu_src = 1'b1;
            end
            EST_CALC_END:    ctrl.alu_src   = 1'b1;
            EST_LE_MEM:      ctrl.mem_read  = 1'b1;
            EST_ESCREVE_MEM: ctrl.mem_write = 1'b1;
            EST_ESCREVE_REG: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (opcode_r_q == OP_LW);
            end
            EST_DESVIO: ctrl.alu_op = ALU_SUB;
            default:    ctrl.alu_op = ALU_ADD;
        endcase
    end

    assign bus.estado     = estado_q;
    assign bus.PC         = pc_q;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src    = ctrl.alu_src;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.erro       = erro_q;
    assign bus.n_exec     = n_exec_q;
endmodule
